// File: rtl/usr_gen.sv
// usr_gen: parametrised universal shift register with rotate/arith/clear
// modes and an autonomous N-step burst engine with busy/done handshake.
module usr_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             s_in_left,
  input  logic             s_in_right,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             s_out_left,
  output logic             s_out_right,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [0:0]       state;
  logic [2:0]       bmode;
  logic [CNT_W-1:0] rem;

  logic [2:0]       op;
  logic [WIDTH-1:0] q_next;
  logic             legal;

  // In BURST the latched mode drives the datapath; live mode is ignored.
  assign op = (state == BURST) ? bmode : mode;

  always_comb begin
    q_next = q;
    case (op)
      M_HOLD: q_next = q;
      M_SHR:  q_next = {s_in_left, q[WIDTH-1:1]};
      M_SHL:  q_next = {q[WIDTH-2:0], s_in_right};
      M_LOAD: q_next = d_in;
      M_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      M_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      M_CLR:  q_next = '0;
      default: q_next = q;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (mode)
      M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      state <= IDLE;
      bmode <= M_HOLD;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && legal) begin
            if (count != '0) begin
              bmode <= mode;
              rem   <= count;
              state <= BURST;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            q <= q_next;
          end
        end
        BURST: begin
          if (en) begin
            q   <= q_next;
            rem <= rem - ONE;
            if (rem == ONE) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state == BURST);
  assign s_out_left  = q[WIDTH-1];
  assign s_out_right = q[0];

endmodule

// File: tb/tb_usr_gen.sv
// tb_usr_gen: directed-vector bench for usr_gen (WIDTH=8).
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_usr_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d_in;
  logic       s_in_left;
  logic       s_in_right;
  logic       start;
  logic [3:0] count;
  logic [7:0] q;
  logic       s_out_left;
  logic       s_out_right;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  usr_gen #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .d_in(d_in),
    .s_in_left(s_in_left),
    .s_in_right(s_in_right),
    .start(start),
    .count(count),
    .q(q),
    .s_out_left(s_out_left),
    .s_out_right(s_out_right),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'b011;
    d_in = v;
    en = 1'b1;
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    mode = 3'b011;
    d_in = 8'hFF;
    start = 1'b1;
    count = 4'd3;
    s_in_left = 1'b1;
    s_in_right = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset: q=%h busy=%b done=%b want 00/0/0", q, busy, done);
    end
    rst = 1'b0;
    start = 1'b0;
    mode = 3'b000;
    tick();
    tick();
    checks++;
    if (q !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold: q=%h want 00", q);
    end
  endtask

  task automatic test_load_shift();
    load(8'hB5);
    checks++;
    if (q !== 8'hB5) begin
      failures++;
      $display("FAIL load: q=%h want b5", q);
    end
    mode = 3'b001;
    s_in_left = 1'b1;
    tick();
    checks++;
    if (q !== 8'hDA) begin
      failures++;
      $display("FAIL shr: q=%h want da", q);
    end
    en = 1'b0;
    mode = 3'b111;
    tick();
    checks++;
    if (q !== 8'hDA) begin
      failures++;
      $display("FAIL en_hold: q=%h want da", q);
    end
  endtask

  task automatic test_shl_asr();
    load(8'h80);
    mode = 3'b110;
    tick();
    checks++;
    if (q !== 8'hC0) begin
      failures++;
      $display("FAIL asr1: q=%h want c0", q);
    end
    tick();
    checks++;
    if (q !== 8'hE0) begin
      failures++;
      $display("FAIL asr2: q=%h want e0", q);
    end
    load(8'h81);
    checks++;
    if (s_out_left !== 1'b1 || s_out_right !== 1'b1) begin
      failures++;
      $display("FAIL sout_81: l=%b r=%b want 1/1", s_out_left, s_out_right);
    end
    mode = 3'b010;
    s_in_right = 1'b0;
    tick();
    checks++;
    if (q !== 8'h02 || s_out_left !== 1'b0 || s_out_right !== 1'b0) begin
      failures++;
      $display("FAIL shl: q=%h l=%b r=%b want 02/0/0", q, s_out_left, s_out_right);
    end
    mode = 3'b111;
    tick();
    checks++;
    if (q !== 8'h00) begin
      failures++;
      $display("FAIL clear: q=%h want 00", q);
    end
  endtask

  task automatic test_burst_rotl();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h6B;
    exp_q[1] = 8'hD6;
    exp_q[2] = 8'hAD;
    load(8'hB5);
    mode = 3'b101;
    count = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 3'b011;
    d_in = 8'h00;
    checks++;
    if (q !== 8'hB5 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL rotl_e0: q=%h busy=%b done=%b want b5/1/0", q, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
        failures++;
        $display("FAIL rotl_step%0d: q=%h busy=%b done=%b want %h/%b/%b",
                 i, q, busy, done, exp_q[i], i < 2, i == 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Start sampled while done from the previous burst is still high.
    mode = 3'b101;
    count = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 3'b000;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || q !== 8'hAD) begin
      failures++;
      $display("FAIL b2b_start: busy=%b done=%b q=%h want 1/0/ad", busy, done, q);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_mid: busy=%b done=%b want 1/0", busy, done);
    end
    tick();
    checks++;
    if (q !== 8'hAD || busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL rot8: q=%h busy=%b done=%b want ad/0/1", q, busy, done);
    end
    en = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_clear: done=%b busy=%b want 0/0", done, busy);
    end
    en = 1'b1;
  endtask

  task automatic test_burst_pause();
    load(8'h01);
    mode = 3'b100;
    count = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (q !== 8'h80 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pause_step1: q=%h busy=%b want 80/1", q, busy);
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (q !== 8'h80 || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold%0d: q=%h busy=%b done=%b want 80/1/0",
                 i, q, busy, done);
      end
    end
    en = 1'b1;
    tick();
    tick();
    checks++;
    if (q !== 8'h20 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL pause_step3: q=%h busy=%b done=%b want 20/1/0", q, busy, done);
    end
    tick();
    checks++;
    if (q !== 8'h10 || busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL pause_end: q=%h busy=%b done=%b want 10/0/1", q, busy, done);
    end
    mode = 3'b000;
    tick();
  endtask

  task automatic test_abort_corners();
    logic seen_done;
    load(8'h0F);
    mode = 3'b001;
    s_in_left = 1'b0;
    count = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (q !== 8'h07 || busy !== 1'b1) begin
      failures++;
      $display("FAIL burst_shr: q=%h busy=%b want 07/1", q, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 3'b000;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort: q=%h busy=%b done=%b want 00/0/0", q, busy, done);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone: activity=%b want 0", seen_done);
    end
    load(8'h3C);
    mode = 3'b001;
    count = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 3'b000;
    checks++;
    if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL count0: q=%h busy=%b done=%b want 3c/0/1", q, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL count0_clear: done=%b want 0", done);
    end
    mode = 3'b011;
    d_in = 8'h5A;
    count = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 3'b000;
    checks++;
    if (q !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_load: q=%h busy=%b done=%b want 5a/0/0", q, busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h5A) begin
      failures++;
      $display("FAIL start_load2: q=%h busy=%b done=%b want 5a/0/0", q, busy, done);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    en = 1'b0;
    mode = 3'b000;
    d_in = 8'h00;
    s_in_left = 1'b0;
    s_in_right = 1'b0;
    start = 1'b0;
    count = 4'd0;
    test_reset();
    test_load_shift();
    test_shl_asr();
    test_burst_rotl();
    test_back_to_back();
    test_burst_pause();
    test_abort_corners();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
